// File: rtl/aurora_event_gate.sv
// Frame-aware N-channel pass/trash gate for TURFIO Aurora event streams.
// Optional stall watchdog enabled by defining AURORA_EVENT_GATE_WATCHDOG_EN.
module aurora_event_gate #(
   parameter int NCHAN          = 4,
   parameter int DW             = 32,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       event_open_i,
   input  logic [NCHAN-1:0]           chan_mask_i,
   input  logic                       clear_i,
   input  logic [NCHAN*DW-1:0]        s_axis_tdata,
   input  logic [NCHAN-1:0]           s_axis_tvalid,
   output logic [NCHAN-1:0]           s_axis_tready,
   input  logic [NCHAN-1:0]           s_axis_tlast,
   output logic [NCHAN*DW-1:0]        m_axis_tdata,
   output logic [NCHAN-1:0]           m_axis_tvalid,
   input  logic [NCHAN-1:0]           m_axis_tready,
   output logic [NCHAN-1:0]           m_axis_tlast,
   output logic [NCHAN-1:0]           in_frame_o,
   output logic [NCHAN*CNT_WIDTH-1:0] pass_count_o,
   output logic [NCHAN*CNT_WIDTH-1:0] drop_count_o,
   output logic [NCHAN-1:0]           stall_o
);

   (* ASYNC_REG = "TRUE" *) logic [1:0] open_sync;
   logic             open_q;
   logic [NCHAN-1:0] in_frame;
   logic [NCHAN-1:0] mode;
   logic [NCHAN-1:0] eff;
   logic [NCHAN-1:0] acc;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         open_sync <= 2'b00;
      end else begin
         open_sync <= {open_sync[0], event_open_i};
      end
   end

   assign open_q = open_sync[1];

   // Decision is latched while mid-frame; open/mask only matter at frame start.
   always_comb begin
      eff           = '0;
      acc           = '0;
      s_axis_tready = '0;
      m_axis_tvalid = '0;
      for (int i = 0; i < NCHAN; i++) begin
         eff[i]           = in_frame[i] ? mode[i]
                                        : (open_q & ~chan_mask_i[i]);
         s_axis_tready[i] = eff[i] ? m_axis_tready[i] : 1'b1;
         m_axis_tvalid[i] = eff[i] & s_axis_tvalid[i];
         acc[i]           = s_axis_tvalid[i]
                          & (~eff[i] | m_axis_tready[i]);
      end
   end

   assign m_axis_tdata = s_axis_tdata;
   assign m_axis_tlast = s_axis_tlast;
   assign in_frame_o   = in_frame;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         in_frame <= '0;
         mode     <= '0;
      end else begin
         for (int i = 0; i < NCHAN; i++) begin
            if (acc[i]) begin
               in_frame[i] <= ~s_axis_tlast[i];
               if (!s_axis_tlast[i]) begin
                  mode[i] <= eff[i];
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NCHAN; g++) begin : g_ch
      logic [CNT_WIDTH-1:0] pass_cnt;
      logic [CNT_WIDTH-1:0] drop_cnt;
      logic                 eof;

      assign eof = acc[g] & s_axis_tlast[g];

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
         end else if (clear_i) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
         end else if (eof) begin
            if (eff[g]) begin
               if (pass_cnt != '1) begin
                  pass_cnt <= pass_cnt + CNT_WIDTH'(1);
               end
            end else begin
               if (drop_cnt != '1) begin
                  drop_cnt <= drop_cnt + CNT_WIDTH'(1);
               end
            end
         end
      end

      assign pass_count_o[g*CNT_WIDTH +: CNT_WIDTH] = pass_cnt;
      assign drop_count_o[g*CNT_WIDTH +: CNT_WIDTH] = drop_cnt;

`ifdef AURORA_EVENT_GATE_WATCHDOG_EN
      localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [WW-1:0] WMAX = WW'(TIMEOUT_CYCLES);

      logic [WW-1:0] wd_cnt;
      logic [WW-1:0] wd_nxt;
      logic          stall;

      // Idle-in-frame cycle count, parked at the threshold.
      always_comb begin
         wd_nxt = wd_cnt;
         if (!in_frame[g] || acc[g]) begin
            wd_nxt = '0;
         end else if (wd_cnt != WMAX) begin
            wd_nxt = wd_cnt + WW'(1);
         end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            wd_cnt <= '0;
            stall  <= 1'b0;
         end else if (clear_i) begin
            wd_cnt <= '0;
            stall  <= 1'b0;
         end else begin
            wd_cnt <= wd_nxt;
            if (wd_nxt == WMAX) begin
               stall <= 1'b1;
            end
         end
      end

      assign stall_o[g] = stall;
`else
      assign stall_o[g] = 1'b0;
`endif
   end

endmodule
